// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL,
// REF_CNT AUTO REFRESH, LOAD MODE REGISTER, then a sticky o_init_done.
module sdram_init_seq #(
   parameter int unsigned T_POWERUP = 10000,
   parameter int unsigned T_RP      = 3,
   parameter int unsigned T_RFC     = 7,
   parameter int unsigned T_MRD     = 3,
   parameter int unsigned REF_CNT   = 8,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned BA_W      = 2,
   parameter logic [12:0] MODE_REG  = 13'h032
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_cke,
   output logic [3:0]        o_cmd,
   output logic [BA_W-1:0]   o_ba,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_init_done
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   localparam logic [2:0] WAIT_PWR = 3'd0;
   localparam logic [2:0] PRE      = 3'd1;
   localparam logic [2:0] WAIT_RP  = 3'd2;
   localparam logic [2:0] REF      = 3'd3;
   localparam logic [2:0] WAIT_RFC = 3'd4;
   localparam logic [2:0] MRS      = 3'd5;
   localparam logic [2:0] WAIT_MRD = 3'd6;
   localparam logic [2:0] DONE     = 3'd7;

   localparam int unsigned MAX_A = (T_POWERUP > T_RP)  ? T_POWERUP : T_RP;
   localparam int unsigned MAX_B = (T_RFC > T_MRD)     ? T_RFC     : T_MRD;
   localparam int unsigned MAX_T = (MAX_A > MAX_B)     ? MAX_A     : MAX_B;
   localparam int CNT_W = $clog2(MAX_T + 1);
   localparam int REF_W = $clog2(REF_CNT + 1);

   localparam logic [CNT_W-1:0]  PWR_END  = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0]  RP_END   = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0]  RFC_END  = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0]  MRD_END  = CNT_W'(T_MRD - 1);
   localparam logic [REF_W-1:0]  REF_END  = REF_W'(REF_CNT);
   localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(32'h0000_0400);
   localparam logic [ADDR_W-1:0] MODE_VAL = ADDR_W'(MODE_REG);

   logic [2:0]        state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [REF_W-1:0]  ref_r, ref_s;
   logic [3:0]        cmd_s;
   logic [ADDR_W-1:0] addr_s;
   logic [BA_W-1:0]   ba_s;
   logic              done_s;

   // Next-state and next-output logic; the command register is loaded on the
   // same edge the state enters the matching command state.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CNT_W'(1);
      ref_s   = ref_r;
      cmd_s   = CMD_NOP;
      addr_s  = '0;
      ba_s    = '0;
      done_s  = o_init_done;
      case (state_r)
         WAIT_PWR: begin
            if (cnt_r == PWR_END) begin
               state_s = PRE;
               cnt_s   = '0;
               cmd_s   = CMD_PRE;
               addr_s  = PRE_ADDR;
            end else begin
               state_s = WAIT_PWR;
            end
         end
         PRE, WAIT_RP: begin
            if (cnt_r == RP_END) begin
               state_s = REF;
               cnt_s   = '0;
               cmd_s   = CMD_REF;
               ref_s   = ref_r + REF_W'(1);
            end else begin
               state_s = WAIT_RP;
            end
         end
         REF, WAIT_RFC: begin
            if (cnt_r != RFC_END) begin
               state_s = WAIT_RFC;
            end else if (ref_r == REF_END) begin
               state_s = MRS;
               cnt_s   = '0;
               cmd_s   = CMD_LMR;
               addr_s  = MODE_VAL;
            end else begin
               state_s = REF;
               cnt_s   = '0;
               cmd_s   = CMD_REF;
               ref_s   = ref_r + REF_W'(1);
            end
         end
         MRS, WAIT_MRD: begin
            if (cnt_r == MRD_END) begin
               state_s = DONE;
               cnt_s   = '0;
               done_s  = 1'b1;
            end else begin
               state_s = WAIT_MRD;
            end
         end
         DONE: begin
            cnt_s  = '0;
            done_s = 1'b1;
         end
         default: begin
            state_s = WAIT_PWR;
            cnt_s   = '0;
            ref_s   = '0;
            done_s  = 1'b0;
         end
      endcase
   end

   // State, counters and all outputs are registered; reset is asynchronous.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r     <= WAIT_PWR;
         cnt_r       <= '0;
         ref_r       <= '0;
         o_cke       <= 1'b0;
         o_cmd       <= CMD_NOP;
         o_ba        <= '0;
         o_addr      <= '0;
         o_init_done <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         ref_r       <= ref_s;
         o_cke       <= 1'b1;
         o_cmd       <= cmd_s;
         o_ba        <= ba_s;
         o_addr      <= addr_s;
         o_init_done <= done_s;
      end
   end

endmodule
